sum_accumulator: RTL and testbench

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_accumulator.sv | 119 +++++++++++
 tb/tb_sum_accumulator.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// Sums windows of 2^LOG2_N samples and reports total and truncated average; optional min/max via MIN_MAX_EN.
// Latency: result registered, out_valid high the cycle after the window's last accepted sample.
// Backpressure: a pending result holds in_ready low until out_ready; clear aborts the window at any time.
module sum_accumulator #(
    parameter int LOG2_N = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        clear,
    output logic [15:0] out_sum,
    output logic [7:0]  out_avg,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef MIN_MAX_EN
    output logic [7:0]  out_min,
    output logic [7:0]  out_max,
`endif
    output logic        busy
);

    localparam int CW = LOG2_N + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'((1 << LOG2_N) - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]    state;
    logic [15:0]   acc;
    logic [CW-1:0] count;
    logic          accept;
    logic          last_accept;
    logic [15:0]   sum_next;

    assign in_ready    = (state != ST_HOLD) && !clear;
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (state == ST_ACCUM) && (count == LAST_CNT);
    assign sum_next    = acc + {8'd0, in_data};
    assign busy        = (state != ST_IDLE);

`ifdef MIN_MAX_EN
    logic [7:0] run_min;
    logic [7:0] run_max;
    logic [7:0] min_next;
    logic [7:0] max_next;

    assign min_next = (in_data < run_min) ? in_data : run_min;
    assign max_next = (in_data > run_max) ? in_data : run_max;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            run_min <= 8'd0;
            run_max <= 8'd0;
            out_min <= 8'd0;
            out_max <= 8'd0;
        end else if (accept && state == ST_IDLE) begin
            // first sample of a window seeds both trackers
            run_min <= in_data;
            run_max <= in_data;
        end else if (accept && state == ST_ACCUM) begin
            run_min <= min_next;
            run_max <= max_next;
            if (last_accept) begin
                out_min <= min_next;
                out_max <= max_next;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state     <= ST_IDLE;
            acc       <= 16'd0;
            count     <= '0;
            out_sum   <= 16'd0;
            out_avg   <= 8'd0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        acc   <= {8'd0, in_data};
                        count <= CW'(1);
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        acc   <= sum_next;
                        count <= count + CW'(1);
                        if (last_accept) begin
                            out_sum   <= sum_next;
                            out_avg   <= 8'(sum_next >> LOG2_N);
                            out_valid <= 1'b1;
                            state     <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // in_ready is low here, so a sample offered alongside the handshake waits a cycle
                    if (out_ready) begin
                        acc       <= 16'd0;
                        count     <= '0;
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator (LOG2_N = 2): directed scenarios then random traffic against a queue-based window model.
module tb_sum_accumulator;

    localparam int LOG2_N = 2;
    localparam int N = 1 << LOG2_N;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        clear = 1'b0;
    logic [15:0] out_sum;
    logic [7:0]  out_avg;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
`ifdef MIN_MAX_EN
    logic [7:0]  out_min;
    logic [7:0]  out_max;
`endif

    sum_accumulator #(.LOG2_N(LOG2_N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .clear(clear),
        .out_sum(out_sum),
        .out_avg(out_avg),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef MIN_MAX_EN
        .out_min(out_min),
        .out_max(out_max),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the window is simply the list of accepted samples.
    int win[$];
    bit pending = 0;
    bit known = 0;
    int last_sum = 0;
    int last_avg = 0;
    int last_min = 0;
    int last_max = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_edge(input bit v, input int d, input bit c, input bit r, input bit rn);
        int s;
        int mn;
        int mx;
        if (!rn || c) begin
            win.delete();
            pending = 0;
            last_sum = 0;
            last_avg = 0;
            last_min = 0;
            last_max = 0;
        end else if (pending) begin
            if (r) begin
                pending = 0;
                win.delete();
            end
        end else if (v) begin
            win.push_back(d);
            if (win.size() == N) begin
                s = 0;
                mn = 255;
                mx = 0;
                foreach (win[i]) begin
                    s += win[i];
                    if (win[i] < mn) mn = win[i];
                    if (win[i] > mx) mx = win[i];
                end
                last_sum = s;
                last_avg = s / N;
                last_min = mn;
                last_max = mx;
                pending = 1;
                win.delete();
            end
        end
    endtask

    // Drive one cycle from a negedge, check combinational ready before the edge, registered outputs after.
    task automatic step(input bit v, input int d, input bit c, input bit r, input bit rn);
        in_valid = v;
        in_data = 8'(d);
        clear = c;
        out_ready = r;
        rst_n = rn;
        #1;
        if (known) chk("in_ready", {15'd0, in_ready}, {15'd0, !pending && !c});
        @(posedge clk);
        model_edge(v, d, c, r, rn);
        known = 1;
        @(negedge clk);
        chk("out_valid", {15'd0, out_valid}, {15'd0, pending});
        chk("out_sum", out_sum, 16'(last_sum));
        chk("out_avg", {8'd0, out_avg}, 16'(last_avg));
        chk("busy", {15'd0, busy}, {15'd0, pending || win.size() != 0});
`ifdef MIN_MAX_EN
        chk("out_min", {8'd0, out_min}, 16'(last_min));
        chk("out_max", {8'd0, out_max}, 16'(last_max));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq_a[4];
        int seq_b[4];
        seq_a = '{10, 20, 30, 40};
        seq_b = '{1, 2, 3, 5};
        @(negedge clk);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("reset_sum", out_sum, 16'd0);
        chk("reset_busy", {15'd0, busy}, 16'd0);

        foreach (seq_a[i]) step(1, seq_a[i], 0, 0, 1);
        chk("b2b_valid", {15'd0, out_valid}, 16'd1);
        chk("b2b_sum", out_sum, 16'd100);
        chk("b2b_avg", {8'd0, out_avg}, 16'd25);
        chk("b2b_busy", {15'd0, busy}, 16'd1);
        step(0, 0, 0, 1, 1);

        for (int i = 0; i < 4; i++) begin
            step(1, 255, 0, 0, 1);
            if (i < 3) for (int g = 0; g < 3; g++) step(0, 0, 0, 0, 1);
        end
        chk("max_sum", out_sum, 16'd1020);
        chk("max_avg", {8'd0, out_avg}, 16'd255);
        step(0, 0, 0, 1, 1);

        for (int i = 1; i <= 4; i++) step(1, i, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 99, 0, 0, 1);
        chk("hold_sum_stable", out_sum, 16'd10);
        step(1, 99, 0, 1, 1);
        chk("hold_release_busy", {15'd0, busy}, 16'd0);
        step(1, 99, 0, 0, 1);
        chk("held_sample_taken", {15'd0, busy}, 16'd1);
        step(1, 50, 0, 0, 1);
        step(1, 77, 1, 0, 1);
        chk("clear_sum", out_sum, 16'd0);
        chk("clear_busy", {15'd0, busy}, 16'd0);
        foreach (seq_b[i]) step(1, seq_b[i], 0, 0, 1);
        chk("after_clear_sum", out_sum, 16'd11);
        chk("after_clear_avg", {8'd0, out_avg}, 16'd2);

        step(1, 9, 0, 0, 0);
        chk("rst_hold_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_hold_sum", out_sum, 16'd0);
        chk("rst_hold_busy", {15'd0, busy}, 16'd0);
        step(0, 0, 0, 0, 1);

`ifdef MIN_MAX_EN
        step(1, 7, 0, 0, 1);
        step(1, 200, 0, 0, 1);
        step(1, 3, 0, 0, 1);
        step(1, 90, 0, 0, 1);
        chk("mm_min", {8'd0, out_min}, 16'd3);
        chk("mm_max", {8'd0, out_max}, 16'd200);
        chk("mm_sum", out_sum, 16'd300);
        chk("mm_avg", {8'd0, out_avg}, 16'd75);
        step(0, 0, 0, 1, 1);
`endif

        for (int i = 0; i < 400; i++) begin
            int d;
            case ($urandom_range(0, 3))
                0: d = 0;
                1: d = 255;
                default: d = int'($urandom_range(0, 255));
            endcase
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 59) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
